// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and constants for the DRAM port arbiter between the fetch
// channel and the MEM-stage load/store channel.
package dram_port_arbiter_pkg;

  localparam int WR_CTRL_W = 2;
  localparam int RD_CTRL_W = 3;

  // Read-control code the fetch channel presents for instruction reads.
  localparam logic [RD_CTRL_W-1:0] IF_RD_CTRL = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/dram_port_arbiter_if.sv
// DRAM-side request/acknowledge bus: the arbiter is the master, the DRAM
// controller the slave.
interface dram_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  import dram_port_arbiter_pkg::*;

  logic                 dram_req;
  logic                 dram_we;
  logic [ADDR_W-1:0]    dram_addr;
  logic [DATA_W-1:0]    dram_wdata;
  logic [WR_CTRL_W-1:0] dram_wr_ctrl;
  logic [RD_CTRL_W-1:0] dram_rd_ctrl;
  logic                 dram_ack;
  logic [DATA_W-1:0]    dram_rdata;

  modport master (
    output dram_req, dram_we, dram_addr, dram_wdata, dram_wr_ctrl, dram_rd_ctrl,
    input  dram_ack, dram_rdata
  );

  modport slave (
    input  dram_req, dram_we, dram_addr, dram_wdata, dram_wr_ctrl, dram_rd_ctrl,
    output dram_ack, dram_rdata
  );

endinterface

// File: rtl/dram_port_arbiter.sv
// Single-outstanding arbiter for the data-DRAM port: MEM has priority, IF is
// forced after MAX_MEM_STREAK consecutive MEM grants while IF waits.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  input  logic [RD_CTRL_W-1:0] if_rd_ctrl,
  input  logic                 if_flush,
  output logic [DATA_W-1:0]    if_rdata,
  output logic                 if_valid,
  output logic                 if_stall,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_wdata,
  input  logic [WR_CTRL_W-1:0] mem_wr_ctrl,
  input  logic [RD_CTRL_W-1:0] mem_rd_ctrl,
  output logic [DATA_W-1:0]    mem_rdata,
  output logic                 mem_valid,
  output logic                 mem_stall,
  dram_port_arbiter_if.master  dram
);

  localparam int STREAK_W = $clog2(MAX_MEM_STREAK + 1);

  arb_state_t           state_r, state_s;
  owner_t               owner_r;
  logic [STREAK_W-1:0]  streak_r;
  logic                 drop_r;
  logic                 grant_if_s, grant_mem_s;
  logic                 streak_max_s, busy_s, ack_s;

  logic                 dram_req_r, dram_we_r;
  logic [ADDR_W-1:0]    dram_addr_r;
  logic [DATA_W-1:0]    dram_wdata_r;
  logic [WR_CTRL_W-1:0] dram_wr_ctrl_r;
  logic [RD_CTRL_W-1:0] dram_rd_ctrl_r;
  logic [DATA_W-1:0]    if_rdata_r, mem_rdata_r;

  assign streak_max_s = (streak_r == STREAK_W'(MAX_MEM_STREAK));
  assign busy_s       = (state_r == BUSY_IF) || (state_r == BUSY_MEM);
  assign ack_s        = busy_s && dram.dram_ack;

  // Next-state and grant decision; grants are only made from IDLE.
  always_comb begin
    state_s     = state_r;
    grant_if_s  = 1'b0;
    grant_mem_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_req && mem_req && streak_max_s) begin
          grant_if_s = 1'b1;
          state_s    = BUSY_IF;
        end else if (mem_req) begin
          grant_mem_s = 1'b1;
          state_s     = BUSY_MEM;
        end else if (if_req) begin
          grant_if_s = 1'b1;
          state_s    = BUSY_IF;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (dram.dram_ack) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // DRAM request fields, streak counter and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r        <= OWN_IF;
      streak_r       <= '0;
      dram_req_r     <= 1'b0;
      dram_we_r      <= 1'b0;
      dram_addr_r    <= '0;
      dram_wdata_r   <= '0;
      dram_wr_ctrl_r <= '0;
      dram_rd_ctrl_r <= '0;
      if_rdata_r     <= '0;
      mem_rdata_r    <= '0;
    end else if (grant_if_s) begin
      owner_r        <= OWN_IF;
      streak_r       <= '0;
      dram_req_r     <= 1'b1;
      dram_we_r      <= 1'b0;
      dram_addr_r    <= if_addr;
      dram_wdata_r   <= '0;
      dram_wr_ctrl_r <= '0;
      dram_rd_ctrl_r <= if_rd_ctrl;
    end else if (grant_mem_s) begin
      owner_r        <= OWN_MEM;
      dram_req_r     <= 1'b1;
      dram_we_r      <= mem_we;
      dram_addr_r    <= mem_addr;
      dram_wdata_r   <= mem_wdata;
      dram_wr_ctrl_r <= mem_wr_ctrl;
      dram_rd_ctrl_r <= mem_rd_ctrl;
      // Streak only grows while fetch is actually being held off.
      if (!if_req) begin
        streak_r <= '0;
      end else if (!streak_max_s) begin
        streak_r <= streak_r + STREAK_W'(1'b1);
      end
    end else if (ack_s) begin
      dram_req_r <= 1'b0;
      if (owner_r == OWN_IF) begin
        if (!drop_r && !if_flush) begin
          if_rdata_r <= dram.dram_rdata;
        end
      end else if (!dram_we_r) begin
        mem_rdata_r <= dram.dram_rdata;
      end
    end
  end

  // A redirect while the fetch is in flight poisons its result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_r <= 1'b0;
    end else if (state_r == DONE) begin
      drop_r <= 1'b0;
    end else if ((state_r == BUSY_IF) && if_flush) begin
      drop_r <= 1'b1;
    end
  end

  assign if_valid  = (state_r == DONE) && (owner_r == OWN_IF) && !drop_r && !if_flush;
  assign mem_valid = (state_r == DONE) && (owner_r == OWN_MEM);
  assign if_stall  = if_req && !if_valid && !reset;
  assign mem_stall = mem_req && !mem_valid && !reset;
  assign if_rdata  = if_rdata_r;
  assign mem_rdata = mem_rdata_r;

  assign dram.dram_req     = dram_req_r;
  assign dram.dram_we      = dram_we_r;
  assign dram.dram_addr    = dram_addr_r;
  assign dram.dram_wdata   = dram_wdata_r;
  assign dram.dram_wr_ctrl = dram_wr_ctrl_r;
  assign dram.dram_rd_ctrl = dram_rd_ctrl_r;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: table-driven single transactions,
// a response scoreboard, and hand-written contention/flush/reset sequences.
module tb_dram_port_arbiter;
  import dram_port_arbiter_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;

  typedef struct {
    logic        is_if;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  wr_ctrl;
    logic [2:0]  rd_ctrl;
    logic        flush;
    logic [63:0] exp_rdata;
    int          exp_lat;
    int          ack_delay;
  } job_t;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  wr_ctrl;
    logic [2:0]  rd_ctrl;
  } grant_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        if_req, if_flush, if_valid, if_stall;
  logic [63:0] if_addr, if_rdata;
  logic [2:0]  if_rd_ctrl;
  logic        mem_req, mem_we, mem_valid, mem_stall;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_wr_ctrl;
  logic [2:0]  mem_rd_ctrl;

  dram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dram ();

  dram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_MEM_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rd_ctrl(if_rd_ctrl), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_ctrl(mem_wr_ctrl), .mem_rd_ctrl(mem_rd_ctrl),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_stall(mem_stall),
    .dram(dram)
  );

  int          checks = 0;
  int          failures = 0;
  int          ack_delay = 0;
  int          if_pulses = 0;
  bit          if_busy, mem_busy;
  job_t        if_jobs[$];
  job_t        mem_jobs[$];
  logic [63:0] if_exp_q[$];
  logic [63:0] mem_exp_q[$];
  grant_t      grant_q[$];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dram_fn(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h0000_0000_0000_0013;
    return a ^ 64'hA5A5_0000_0000_0000;
  endfunction

  function automatic job_t mk(input logic is_if, input logic we, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [1:0] wr, input logic [2:0] rd,
                              input logic flush, input logic [63:0] exp, input int lat, input int dly);
    job_t j;
    j.is_if = is_if; j.we = we; j.addr = addr; j.wdata = wdata; j.wr_ctrl = wr;
    j.rd_ctrl = rd; j.flush = flush; j.exp_rdata = exp; j.exp_lat = lat; j.ack_delay = dly;
    return j;
  endfunction

  function automatic grant_t cur_grant();
    grant_t g;
    g.we = dram.dram_we; g.addr = dram.dram_addr; g.wdata = dram.dram_wdata;
    g.wr_ctrl = dram.dram_wr_ctrl; g.rd_ctrl = dram.dram_rd_ctrl;
    return g;
  endfunction

  task automatic check_grant(input string name, input job_t j);
    grant_t g;
    logic   ok;
    checks++;
    if (grant_q.size() == 0) begin
      failures++;
      $display("FAIL %s: no DRAM transaction logged, expected addr %h", name, j.addr);
    end else begin
      g  = grant_q.pop_front();
      ok = (g.addr == j.addr) && (g.rd_ctrl == j.rd_ctrl) &&
           (g.we == (j.is_if ? 1'b0 : j.we)) && (g.wr_ctrl == (j.is_if ? 2'b00 : j.wr_ctrl)) &&
           (j.is_if || (g.wdata == j.wdata));
      if (!ok) begin
        failures++;
        $display("FAIL %s: got addr=%h we=%b wdata=%h wr=%b rd=%b expected addr=%h we=%b wdata=%h wr=%b rd=%b",
                 name, g.addr, g.we, g.wdata, g.wr_ctrl, g.rd_ctrl, j.addr,
                 j.is_if ? 1'b0 : j.we, j.wdata, j.is_if ? 2'b00 : j.wr_ctrl, j.rd_ctrl);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (n < 1000 && !(if_jobs.size() == 0 && mem_jobs.size() == 0 && !if_busy && !mem_busy &&
                             if_exp_q.size() == 0 && mem_exp_q.size() == 0));
    if (n >= 1000) begin
      checks++; failures++;
      $display("FAIL drain_timeout: requesters still busy after %0d cycles", n);
    end
    repeat (2) @(negedge clk);
  endtask

  // DRAM controller model: acks ack_delay cycles after it first sees dram_req.
  initial begin : dram_model
    int     cnt;
    grant_t first;
    dram.dram_ack = 1'b0;
    dram.dram_rdata = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (dram.dram_req && !dram.dram_ack) begin
        if (cnt == 0) first = cur_grant();
        else begin
          checks++;
          if (cur_grant() != first) begin
            failures++;
            $display("FAIL dram_hold: fields changed to addr=%h we=%b while waiting, expected addr=%h we=%b",
                     dram.dram_addr, dram.dram_we, first.addr, first.we);
          end
        end
        if (cnt >= ack_delay) begin
          dram.dram_ack = 1'b1;
          dram.dram_rdata = dram_fn(dram.dram_addr);
          grant_q.push_back(cur_grant());
        end
        cnt++;
      end else begin
        dram.dram_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Scoreboard: every valid pulse pops the expectation pushed when the request was driven.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (if_valid) begin
        if_pulses++;
        if (if_exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL if_unexpected_valid: got if_valid=1 rdata=%h expected no pulse", if_rdata);
        end else begin
          e = if_exp_q.pop_front();
          check64("if_rdata", if_rdata, e);
        end
      end
      if (mem_valid) begin
        if (mem_exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL mem_unexpected_valid: got mem_valid=1 rdata=%h expected no pulse", mem_rdata);
        end else begin
          e = mem_exp_q.pop_front();
          check64("mem_rdata", mem_rdata, e);
        end
      end
    end
  end

  // Fetch requester: holds its request until if_valid, or redirects on a flush job.
  initial begin : if_requester
    job_t j;
    int   lat, lowc;
    bit   seen;
    if_req = 1'b0; if_flush = 1'b0; if_addr = '0; if_rd_ctrl = '0; if_busy = 1'b0;
    forever begin
      if (if_jobs.size() > 0) begin
        j = if_jobs.pop_front();
        if_busy = 1'b1;
        if_req = 1'b1; if_addr = j.addr; if_rd_ctrl = j.rd_ctrl;
        if (!j.flush) if_exp_q.push_back(j.exp_rdata);
        lat = 0; lowc = 0; seen = 1'b0;
        while (!seen && lat < 300) begin
          @(negedge clk);
          lat++;
          if (j.flush) seen = dram.dram_req && (dram.dram_addr == j.addr);
          else begin
            if (!if_stall) lowc++;
            seen = if_valid;
          end
        end
        #1;
        if (!seen) begin
          checks++; failures++;
          $display("FAIL if_timeout: got no response for addr %h expected one within 300 cycles", j.addr);
          if_req = 1'b0;
        end else if (j.flush) begin
          if_flush = 1'b1; if_req = 1'b0;
          @(negedge clk); #1;
          if_flush = 1'b0;
        end else if (j.exp_lat != 0) begin
          check64("if_latency", 64'(lat), 64'(j.exp_lat));
          check64("if_stall_low_cycles", 64'(lowc), 64'd1);
        end
      end else begin
        if_req = 1'b0; if_busy = 1'b0;
        @(negedge clk); #1;
      end
    end
  end

  // Load/store requester: holds its request until mem_valid.
  initial begin : mem_requester
    job_t j;
    int   lat, lowc;
    bit   seen;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    mem_wr_ctrl = '0; mem_rd_ctrl = '0; mem_busy = 1'b0;
    forever begin
      if (mem_jobs.size() > 0) begin
        j = mem_jobs.pop_front();
        mem_busy = 1'b1;
        mem_req = 1'b1; mem_we = j.we; mem_addr = j.addr; mem_wdata = j.wdata;
        mem_wr_ctrl = j.wr_ctrl; mem_rd_ctrl = j.rd_ctrl;
        mem_exp_q.push_back(j.exp_rdata);
        lat = 0; lowc = 0; seen = 1'b0;
        while (!seen && lat < 300) begin
          @(negedge clk);
          lat++;
          if (!mem_stall) lowc++;
          seen = mem_valid;
        end
        #1;
        if (!seen) begin
          checks++; failures++;
          $display("FAIL mem_timeout: got no response for addr %h expected one within 300 cycles", j.addr);
          mem_req = 1'b0;
        end else if (j.exp_lat != 0) begin
          check64("mem_latency", 64'(lat), 64'(j.exp_lat));
          check64("mem_stall_low_cycles", 64'(lowc), 64'd1);
        end
      end else begin
        mem_req = 1'b0; mem_busy = 1'b0;
        @(negedge clk); #1;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    job_t        vecs[5];
    job_t        j, ja, jb;
    job_t        seq[10];
    int          mi, n;
    logic [63:0] prev_if;

    vecs[0] = mk(1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 2'b00, IF_RD_CTRL, 1'b0,
                 64'h0000_0000_0000_0013, 4, 2);
    vecs[1] = mk(1'b0, 1'b0, 64'h0000_0000_8000_0040, 64'h0, 2'b00, 3'b011, 1'b0,
                 64'hA5A5_0000_8000_0040, 2, 0);
    vecs[2] = mk(1'b0, 1'b1, 64'h0000_0000_8000_0100, 64'h0000_0000_DEAD_BEEF, 2'b10, 3'b000, 1'b0,
                 64'hA5A5_0000_8000_0040, 5, 3);
    vecs[3] = mk(1'b1, 1'b0, 64'h0000_0000_8000_0004, 64'h0, 2'b00, IF_RD_CTRL, 1'b0,
                 64'hA5A5_0000_8000_0004, 3, 1);
    vecs[4] = mk(1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0, 2'b00, 3'b100, 1'b0,
                 64'hB791_5678_9ABC_DEF0, 3, 1);

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check64("reset_ctrl_outputs",
            64'({dram.dram_req, dram.dram_we, dram.dram_wr_ctrl, dram.dram_rd_ctrl,
                 if_valid, if_stall, mem_valid, mem_stall}), 64'd0);
    check64("reset_dram_addr", dram.dram_addr, 64'd0);
    check64("reset_data_regs", if_rdata | mem_rdata | dram.dram_wdata, 64'd0);
    #1 reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      ack_delay = vecs[i].ack_delay;
      if (vecs[i].is_if) if_jobs.push_back(vecs[i]);
      else mem_jobs.push_back(vecs[i]);
      drain();
      check_grant($sformatf("vec%0d_grant", i), vecs[i]);
    end

    // Simultaneous requests with the streak at zero: MEM first, then IF.
    ack_delay = 1;
    ja = mk(1'b0, 1'b0, 64'h0000_0000_8000_0200, 64'h0, 2'b00, 3'b011, 1'b0,
            dram_fn(64'h0000_0000_8000_0200), 0, 1);
    jb = mk(1'b1, 1'b0, 64'h0000_0000_8000_0008, 64'h0, 2'b00, IF_RD_CTRL, 1'b0,
            dram_fn(64'h0000_0000_8000_0008), 0, 1);
    mem_jobs.push_back(ja);
    if_jobs.push_back(jb);
    drain();
    check_grant("simul_first_mem", ja);
    check_grant("simul_then_if", jb);

    // Both requesters saturated: four MEM grants, then IF is forced.
    ack_delay = 0;
    mi = 0; n = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) begin
        seq[k] = mk(1'b1, 1'b0, 64'h0000_0000_8000_2000 + 64'(4 * n), 64'h0, 2'b00, IF_RD_CTRL, 1'b0,
                    dram_fn(64'h0000_0000_8000_2000 + 64'(4 * n)), 0, 0);
        if_jobs.push_back(seq[k]);
        n++;
      end else begin
        seq[k] = mk(1'b0, 1'b0, 64'h0000_0000_8000_1000 + 64'(8 * mi), 64'h0, 2'b00, 3'b011, 1'b0,
                    dram_fn(64'h0000_0000_8000_1000 + 64'(8 * mi)), 0, 0);
        mem_jobs.push_back(seq[k]);
        mi++;
      end
    end
    drain();
    for (int k = 0; k < 10; k++) check_grant($sformatf("streak_grant%0d", k), seq[k]);

    // Flush during BUSY_IF: transaction completes on DRAM, result is dropped.
    prev_if = 64'hA5A5_0000_8000_2004;
    n = if_pulses;
    ack_delay = 3;
    j = mk(1'b1, 1'b0, 64'h0000_0000_8000_3000, 64'h0, 2'b00, IF_RD_CTRL, 1'b1, 64'h0, 0, 3);
    if_jobs.push_back(j);
    drain();
    repeat (6) @(negedge clk);
    check64("flush_no_valid", 64'(if_pulses), 64'(n));
    check64("flush_rdata_kept", if_rdata, prev_if);
    check_grant("flush_dram_completed", j);
    ack_delay = 1;
    j = mk(1'b1, 1'b0, 64'h0000_0000_8000_3004, 64'h0, 2'b00, IF_RD_CTRL, 1'b0,
           dram_fn(64'h0000_0000_8000_3004), 3, 1);
    if_jobs.push_back(j);
    drain();
    check_grant("after_flush_grant", j);

    // Reset while BUSY_MEM; the held request re-arbitrates afterwards.
    ack_delay = 100;
    j = mk(1'b0, 1'b0, 64'h0000_0000_8000_4000, 64'h0, 2'b00, 3'b011, 1'b0,
           dram_fn(64'h0000_0000_8000_4000), 0, 1);
    mem_jobs.push_back(j);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dram.dram_req && n < 20);
    check64("reset_test_req_seen", 64'(dram.dram_req), 64'd1);
    #1 reset = 1'b1;
    #1;
    check64("midreset_outputs",
            64'({dram.dram_req, mem_valid, mem_stall, if_valid, if_stall}), 64'd0);
    ack_delay = 1;
    repeat (2) @(negedge clk);
    check64("midreset_req_held_low", 64'(dram.dram_req), 64'd0);
    #1 reset = 1'b0;
    drain();
    check_grant("after_reset_grant", j);
    check64("after_reset_single_grant", 64'(grant_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
Arbitrates the single data-DRAM port between two requesters: the instruction-fetch channel (fetches from DRAM-resident code) and the MEM-stage load/store channel.
- Holds one outstanding DRAM transaction at a time over a req/ack handshake.
- Returns read data to the granted requester and generates per-requester stall signals.
- Sits between the pipeline's fetch and memory stages and the DRAM controller.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
MAX_MEM_STREAK, 4, max consecutive MEM grants while IF waits before IF is forced

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
if_req  in  1  fetch channel requests a DRAM read
if_addr  in  ADDR_W  fetch address
if_rd_ctrl  in  3  fetch read-control code (fetch uses 3'b101)
if_flush  in  1  branch redirect; discard in-flight fetch result
if_rdata  out  DATA_W  fetch read data
if_valid  out  1  one-cycle pulse, if_rdata valid
if_stall  out  1  fetch must hold request
mem_req  in  1  MEM stage requests access
mem_we  in  1  1 = store, 0 = load
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_wr_ctrl  in  2  store size code
mem_rd_ctrl  in  3  load size/sign code
mem_rdata  out  DATA_W  load data
mem_valid  out  1  one-cycle pulse, access complete
mem_stall  out  1  MEM stage must hold request
dram_req  out  1  transaction request to DRAM
dram_we  out  1  write enable
dram_addr  out  ADDR_W  DRAM address
dram_wdata  out  DATA_W  DRAM write data
dram_wr_ctrl  out  2  DRAM store size
dram_rd_ctrl  out  3  DRAM read control
dram_ack  in  1  DRAM completes current transaction this cycle
dram_rdata  in  DATA_W  DRAM read data, valid with dram_ack

Behaviour:
- Reset values: all outputs 0. State IDLE, streak 0. Reset mid-transaction drops dram_req immediately; no valid is issued. All outputs are always driven; no high-Z.
- FSM states:
  - IDLE:
    - Both requests, streak==MAX_MEM_STREAK → BUSY_IF.
    - Otherwise mem_req → BUSY_MEM.
    - Otherwise if_req → BUSY_IF.
    - On grant, latch the granted requester's addr, ctrl, we and wdata into the dram_* output registers (IF grant forces dram_we=0, dram_wr_ctrl=0).
  - BUSY_IF / BUSY_MEM:
    - dram_req=1 with latched fields held stable until dram_ack.
    - On dram_ack, capture dram_rdata into the owner's rdata register → DONE.
    - DRAM wait time is unbounded; no timeout.
  - DONE:
    - dram_req=0. Owner's valid=1 for exactly this cycle → IDLE.
    - No grant in DONE, so a requester still presenting its completed request is never re-granted.
- Latency: request seen in IDLE at cycle N; dram_req high N+1; earliest ack N+1; valid N+2; next grant considered N+3. Minimum 3 cycles per access.
- Stall signals (combinational):
  - if_stall = if_req & ~if_valid.
  - mem_stall = mem_req & ~mem_valid.
  - Requesters hold request fields stable while stalled.
- Stores: mem_valid pulses on store completion; mem_rdata is unchanged on stores.
- Flush:
  - if_flush while the IF transaction is in BUSY_IF sets a drop flag. The DRAM transaction still completes (not abortable). In DONE, if_valid is suppressed and if_rdata is not updated.
  - if_flush in DONE suppresses that cycle's if_valid.
  - Drop flag clears on leaving DONE.
- Streak counter:
  - MEM grant with if_req=1: increment, saturating at MAX_MEM_STREAK.
  - MEM grant with if_req=0: clear.
  - IF grant: clear.
- Addresses pass through unchecked. Address decode (DRAM vs ROM) is the requesters' job.

Decomposition:
- Shared package: arb_state_t enum (IDLE, BUSY_IF, BUSY_MEM, DONE), owner enum (OWN_IF, OWN_MEM), the fetch read-control constant 3'b101, and the wr/rd ctrl widths.
- DRAM_BASE_ADDR stays in the existing defines.
- No sub-module: FSM, streak counter and output registers fit one module.

Test Plan:
- IF-only read: if_req=1, addr 0x8000_0000; DRAM acks 2 cycles after dram_req with 0x00000013 → if_valid one cycle, if_rdata=0x13, if_stall low only in that cycle.
- Simultaneous requests from IDLE, streak 0 → MEM granted first (dram_addr=mem_addr); IF granted after MEM DONE.
- Starvation guard: MAX_MEM_STREAK=4, mem_req and if_req continuously high → grant sequence MEM,MEM,MEM,MEM,IF, repeating.
- Flush: if_flush pulsed during BUSY_IF → DRAM still acked, if_valid stays 0, if_rdata unchanged; next if_req serviced normally.
- Store: mem_we=1, addr 0x8000_0100, wdata 0xDEADBEEF, wr_ctrl 2'b10 → dram_we=1 with these fields stable until ack; mem_valid pulses; mem_rdata unchanged.
- Reset asserted in BUSY_MEM with dram_req high → dram_req, valids and stalls drop at once; after release, pending requests re-arbitrate from IDLE.
